// File: rtl/spi_collector_pkg.sv
// Shared types for the SPI frame collector: packet flags, phase states, field widths
// and the phase-sequencing helper used at frame start and at every phase end.
package spi_collector_pkg;

  localparam int LEN_W  = 6;
  localparam int BITS_W = 16;

  typedef enum logic [1:0] {
    FLAG_EXACT   = 2'b00,
    FLAG_SHORT   = 2'b01,
    FLAG_LONG    = 2'b10,
    FLAG_CFG_ERR = 2'b11
  } flag_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_TAIL
  } phase_e;

  // Zero-length phases are skipped; everything funnels into TAIL once the data phase is done.
  function automatic phase_e next_phase(input phase_e cur,
                                        input logic [LEN_W-1:0] cmd_len,
                                        input logic [LEN_W-1:0] addr_len,
                                        input logic [BITS_W-1:0] data_len);
    phase_e n;
    n = ST_TAIL;
    if (cur == ST_IDLE && cmd_len != '0)
      n = ST_CMD;
    else if ((cur == ST_IDLE || cur == ST_CMD) && addr_len != '0)
      n = ST_ADDR;
    else if (cur != ST_DATA && cur != ST_TAIL && data_len != '0)
      n = ST_DATA;
    return n;
  endfunction

endpackage

// File: rtl/spi_collector_fifo.sv
// Show-ahead synchronous FIFO; head is valid the cycle after the first write.
// A push while full is refused unless a pop happens in the same cycle.
module spi_collector_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign valid = (count != '0);
  assign head  = mem[rd_ptr];
  assign rd_en = pop & valid;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_collector.sv
// Passive SPI frame collector: splits each chip-select frame into cmd/addr/data and queues one packet.
// Packet is written on the clk edge after the synchronised csn rise; a full FIFO drops the frame (ovf, drop_cnt).
module spi_frame_collector
  import spi_collector_pkg::*;
#(
  parameter int CMD_W      = 32,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter bit QUAD_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  cfg_cmd_len,
  input  logic [LEN_W-1:0]  cfg_addr_len,
  input  logic [BITS_W-1:0] cfg_data_len,
  input  logic              cfg_quad,
  input  logic              spi_sck,
  input  logic              spi_csn,
  input  logic [3:0]        spi_sdo,
  input  logic [3:0]        spi_sdi,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [CMD_W-1:0]  pkt_cmd,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic [DATA_W-1:0] pkt_mosi,
  output logic [DATA_W-1:0] pkt_miso,
  output logic [BITS_W-1:0] pkt_bits,
  output logic [1:0]        pkt_flag,
  output logic              ovf,
  output logic [7:0]        drop_cnt
);

  localparam int PKT_W = CMD_W + ADDR_W + 2 * DATA_W + BITS_W + 2;

  logic [1:0] sck_sync, csn_sync;
  logic [3:0] sdo_s1, sdo_s2, sdi_s1, sdi_s2;
  logic       sck_d, csn_d;
  logic [2:0] sync_live;
  logic       armed;
  logic       sck_rise, csn_rise, csn_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      csn_sync  <= 2'b11;
      sck_d     <= 1'b0;
      csn_d     <= 1'b1;
      sdo_s1    <= '0;
      sdo_s2    <= '0;
      sdi_s1    <= '0;
      sdi_s2    <= '0;
      sync_live <= '0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      csn_sync  <= {csn_sync[0], spi_csn};
      sck_d     <= sck_sync[1];
      csn_d     <= csn_sync[1];
      sdo_s1    <= spi_sdo;
      sdo_s2    <= sdo_s1;
      sdi_s1    <= spi_sdi;
      sdi_s2    <= sdi_s1;
      sync_live <= {sync_live[1:0], 1'b1};
      // Only a fall from a genuinely observed high csn starts a frame, so a reset
      // released mid-frame never picks up the tail of that frame.
      armed     <= armed | (sync_live[2] & csn_d);
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_d;
  assign csn_rise = csn_sync[1] & ~csn_d;
  assign csn_fall = armed & csn_d & ~csn_sync[1];

  phase_e             state, state_nxt;
  logic [LEN_W-1:0]   cmd_len_q, addr_len_q;
  logic [BITS_W-1:0]  data_len_q;
  logic               quad_q;
  logic [BITS_W-1:0]  cnt;
  logic [CMD_W-1:0]   cmd_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  mosi_q, miso_q;
  logic [BITS_W-1:0]  bits_q;
  logic               tail_seen;

  logic [2:0]         step, take;
  logic [BITS_W-1:0]  cur_len, remain;
  logic [BITS_W:0]    bits_sum;
  logic               active, phase_done, cfg_err;
  logic [3:0]         nib_sdo, nib_sdi;
  flag_e              flag;

  always_comb begin
    step    = quad_q ? 3'd4 : 3'd1;
    cur_len = '0;
    active  = 1'b0;
    case (state)
      ST_CMD:  begin cur_len = BITS_W'(cmd_len_q);  active = 1'b1; end
      ST_ADDR: begin cur_len = BITS_W'(addr_len_q); active = 1'b1; end
      ST_DATA: begin cur_len = data_len_q;          active = 1'b1; end
      default: ;
    endcase
    remain     = cur_len - cnt;
    take       = (remain < BITS_W'(step)) ? remain[2:0] : step;
    phase_done = ({1'b0, cnt} + (BITS_W + 1)'(step)) >= {1'b0, cur_len};
    bits_sum   = {1'b0, bits_q} + (BITS_W + 1)'(step);
    // Single-lane bits are placed at the nibble MSB so one shift path serves both modes.
    nib_sdo    = quad_q ? sdo_s2 : {sdo_s2[0], 3'b000};
    nib_sdi    = quad_q ? sdi_s2 : {sdi_s2[1], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (csn_fall)
          state_nxt = next_phase(ST_IDLE, cfg_cmd_len, cfg_addr_len, cfg_data_len);
      end
      default: begin
        if (csn_rise)
          state_nxt = ST_IDLE;
        else if (sck_rise && active && phase_done)
          state_nxt = next_phase(state, cmd_len_q, addr_len_q, data_len_q);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_len_q  <= '0;
      addr_len_q <= '0;
      data_len_q <= '0;
      quad_q     <= 1'b0;
      cnt        <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      mosi_q     <= '0;
      miso_q     <= '0;
      bits_q     <= '0;
      tail_seen  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (csn_fall) begin
        cmd_len_q  <= cfg_cmd_len;
        addr_len_q <= cfg_addr_len;
        data_len_q <= cfg_data_len;
        quad_q     <= QUAD_EN & cfg_quad;
        cnt        <= '0;
        cmd_q      <= '0;
        addr_q     <= '0;
        mosi_q     <= '0;
        miso_q     <= '0;
        bits_q     <= '0;
        tail_seen  <= 1'b0;
      end
    end else if (sck_rise && !csn_rise) begin
      bits_q <= bits_sum[BITS_W] ? '1 : bits_sum[BITS_W-1:0];
      if (active) cnt <= phase_done ? '0 : cnt + BITS_W'(take);
      case (state)
        ST_CMD:  cmd_q  <= (cmd_q  << take) | CMD_W'(nib_sdo >> (3'd4 - take));
        ST_ADDR: addr_q <= (addr_q << take) | ADDR_W'(nib_sdo >> (3'd4 - take));
        ST_DATA: begin
          mosi_q <= (mosi_q << take) | DATA_W'(nib_sdo >> (3'd4 - take));
          miso_q <= (miso_q << take) | DATA_W'(nib_sdi >> (3'd4 - take));
        end
        ST_TAIL: tail_seen <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_err = (int'(cmd_len_q) > CMD_W) || (int'(addr_len_q) > ADDR_W) ||
              (quad_q && (cmd_len_q[1:0] != 2'b00 || addr_len_q[1:0] != 2'b00 ||
                          data_len_q[1:0] != 2'b00));
    if (cfg_err)               flag = FLAG_CFG_ERR;
    else if (state != ST_TAIL) flag = FLAG_SHORT;
    else if (tail_seen)        flag = FLAG_LONG;
    else                       flag = FLAG_EXACT;
  end

  logic             push, pop, fifo_full, drop;
  logic [PKT_W-1:0] push_data, head;

  assign push      = csn_rise & (state != ST_IDLE);
  assign pop       = pkt_valid & pkt_ready;
  assign drop      = push & fifo_full & ~pop;
  assign push_data = {cmd_q, addr_q, mosi_q, miso_q, bits_q, flag};

  spi_collector_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .valid     (pkt_valid),
    .head      (head)
  );

  assign {pkt_cmd, pkt_addr, pkt_mosi, pkt_miso, pkt_bits, pkt_flag} = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_frame_collector.sv
// Scoreboard bench for spi_frame_collector: directed frames plus randomized frames
// checked against a bit-stream reference model.
module tb_spi_frame_collector;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] addr;
    logic [31:0] mosi;
    logic [31:0] miso;
    logic [15:0] bits;
    logic [1:0]  flag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [5:0]  cfg_cmd_len;
  logic [5:0]  cfg_addr_len;
  logic [15:0] cfg_data_len;
  logic        cfg_quad;
  logic        spi_sck;
  logic        spi_csn;
  logic [3:0]  spi_sdo;
  logic [3:0]  spi_sdi;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] pkt_cmd;
  logic [31:0] pkt_addr;
  logic [31:0] pkt_mosi;
  logic [31:0] pkt_miso;
  logic [15:0] pkt_bits;
  logic [1:0]  pkt_flag;
  logic        ovf;
  logic [7:0]  drop_cnt;

  spi_frame_collector dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_cmd_len  (cfg_cmd_len),
    .cfg_addr_len (cfg_addr_len),
    .cfg_data_len (cfg_data_len),
    .cfg_quad     (cfg_quad),
    .spi_sck      (spi_sck),
    .spi_csn      (spi_csn),
    .spi_sdo      (spi_sdo),
    .spi_sdi      (spi_sdi),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_cmd      (pkt_cmd),
    .pkt_addr     (pkt_addr),
    .pkt_mosi     (pkt_mosi),
    .pkt_miso     (pkt_miso),
    .pkt_bits     (pkt_bits),
    .pkt_flag     (pkt_flag),
    .ovf          (ovf),
    .drop_cnt     (drop_cnt)
  );

  int         compared;
  int         mismatched;
  bit         rnd_ready;
  exp_t       sb[$];
  logic [3:0] e_sdo[$];
  logic [3:0] e_sdi[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!rst && pkt_valid && pkt_ready) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pkt: got cmd=%h addr=%h flag=%0d, want no packet", pkt_cmd, pkt_addr, pkt_flag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({pkt_cmd, pkt_addr, pkt_mosi, pkt_miso, pkt_bits, pkt_flag} !==
            {e.cmd, e.addr, e.mosi, e.miso, e.bits, e.flag}) begin
          mismatched++;
          $display("FAIL pkt: got cmd=%h addr=%h mosi=%h miso=%h bits=%0d flag=%0d, want cmd=%h addr=%h mosi=%h miso=%h bits=%0d flag=%0d",
                   pkt_cmd, pkt_addr, pkt_mosi, pkt_miso, pkt_bits, pkt_flag,
                   e.cmd, e.addr, e.mosi, e.miso, e.bits, e.flag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) pkt_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] c, input logic [31:0] a, input logic [31:0] mo,
                              input logic [31:0] mi, input logic [15:0] b, input logic [1:0] f);
    exp_t e;
    e.cmd = c; e.addr = a; e.mosi = mo; e.miso = mi; e.bits = b; e.flag = f;
    return e;
  endfunction

  // Appends the edges that carry an nbits-wide value MSB first on sdo (and sdi).
  task automatic add_edges(input logic [63:0] vo, input logic [63:0] vi, input int nbits, input bit q);
    int lanes;
    lanes = q ? 4 : 1;
    for (int k = 0; k < nbits / lanes; k++) begin
      logic [63:0] to, ti;
      logic [3:0]  no, ni;
      to = vo >> (nbits - (k + 1) * lanes);
      ti = vi >> (nbits - (k + 1) * lanes);
      if (q) begin
        no = to[3:0];
        ni = ti[3:0];
      end else begin
        no = {3'($urandom), to[0]};
        ni = {2'($urandom), ti[0], 1'($urandom)};
      end
      e_sdo.push_back(no);
      e_sdi.push_back(ni);
    end
  endtask

  // Reference: each phase owns ceil(len/lanes) edges and keeps the first len bits they carry.
  function automatic exp_t model(input int c, input int a, input int d, input bit q);
    exp_t        r;
    int          lanes, ne, pos, need, n, lens[3];
    logic [63:0] acc_o, acc_i;
    logic [3:0]  so, si;
    bit          err;
    lanes = q ? 4 : 1;
    ne    = e_sdo.size();
    lens  = '{c, a, d};
    pos   = 0;
    need  = 0;
    r     = mk(0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      n     = (lens[p] + lanes - 1) / lanes;
      acc_o = '0;
      acc_i = '0;
      for (int k = 0; k < n && pos + k < ne; k++) begin
        so = e_sdo[pos + k];
        si = e_sdi[pos + k];
        for (int j = 0; j < lanes; j++) begin
          if (k * lanes + j < lens[p]) begin
            acc_o = {acc_o[62:0], q ? so[3 - j] : so[0]};
            acc_i = {acc_i[62:0], q ? si[3 - j] : si[1]};
          end
        end
      end
      pos  += n;
      need += n;
      if (p == 0) r.cmd = acc_o[31:0];
      if (p == 1) r.addr = acc_o[31:0];
      if (p == 2) begin
        r.mosi = acc_o[31:0];
        r.miso = acc_i[31:0];
      end
    end
    err    = (c > 32) || (a > 32) || (q && ((c % 4) != 0 || (a % 4) != 0 || (d % 4) != 0));
    r.bits = (ne * lanes > 65535) ? 16'hFFFF : 16'(ne * lanes);
    if (err)            r.flag = 2'b11;
    else if (ne < need) r.flag = 2'b01;
    else if (ne > need) r.flag = 2'b10;
    else                r.flag = 2'b00;
    return r;
  endfunction

  task automatic run_frame(input int c, input int a, input int d, input bit q,
                           input bit sync_pop, input int rst_at);
    cfg_cmd_len  = 6'(c);
    cfg_addr_len = 6'(a);
    cfg_data_len = 16'(d);
    cfg_quad     = q;
    repeat (2) tick();
    spi_csn = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < e_sdo.size(); k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end
      spi_sdo = e_sdo[k];
      spi_sdi = e_sdi[k];
      repeat (3) tick();
      spi_sck = 1'b1;
      repeat (3) tick();
      spi_sck = 1'b0;
    end
    repeat (3) tick();
    spi_csn = 1'b1;
    if (sync_pop) begin
      // Ready lands exactly on the cycle the synchronised csn rise pushes the packet.
      repeat (2) tick();
      pkt_ready = 1'b1;
      tick();
      pkt_ready = 1'b0;
    end
    repeat (6) tick();
    e_sdo.delete();
    e_sdi.delete();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    rnd_ready = 1'b0;
    pkt_ready = 1'b1;
    while ((sb.size() != 0 || pkt_valid) && n < 3000) begin
      tick();
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
    pkt_ready = 1'b0;
  endtask

  task automatic std_frame();
    add_edges(64'hA5, 64'($urandom), 8, 1'b0);
    add_edges(64'h3C, 64'($urandom), 8, 1'b0);
    add_edges(64'h1234, 64'hBEEF, 16, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cfg_cmd_len = '0; cfg_addr_len = '0; cfg_data_len = '0; cfg_quad = 1'b0;
    spi_sck = 1'b0; spi_csn = 1'b1; spi_sdo = '0; spi_sdi = '0; pkt_ready = 1'b0;
    rnd_ready = 1'b0; compared = 0; mismatched = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_valid", 64'(pkt_valid), 64'd0);
    check("rst_cmd", 64'(pkt_cmd), 64'd0);
    check("rst_mosi", 64'(pkt_mosi), 64'd0);
    check("rst_bits", 64'(pkt_bits), 64'd0);
    check("rst_flag", 64'(pkt_flag), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    pkt_ready = 1'b1;
    std_frame();
    sb.push_back(mk(32'hA5, 32'h3C, 32'h1234, 32'hBEEF, 16'd32, 2'b00));
    run_frame(8, 8, 16, 1'b0, 1'b0, -1);

    add_edges(64'h0B, 64'($urandom), 8, 1'b1);
    add_edges(64'h123456, 64'($urandom), 24, 1'b1);
    add_edges(64'hCAFEF00D, 64'h600DD00D, 32, 1'b1);
    sb.push_back(mk(32'h0B, 32'h123456, 32'hCAFEF00D, 32'h600DD00D, 16'd64, 2'b00));
    run_frame(8, 24, 32, 1'b1, 1'b0, -1);

    std_frame();
    repeat (20) void'(e_sdo.pop_back());
    repeat (20) void'(e_sdi.pop_back());
    sb.push_back(mk(32'hA5, 32'h3, 32'h0, 32'h0, 16'd12, 2'b01));
    run_frame(8, 8, 16, 1'b0, 1'b0, -1);

    std_frame();
    add_edges(64'($urandom), 64'($urandom), 4, 1'b0);
    sb.push_back(mk(32'hA5, 32'h3C, 32'h1234, 32'hBEEF, 16'd36, 2'b10));
    run_frame(8, 8, 16, 1'b0, 1'b0, -1);
    wait_drain("drain_directed");

    for (int i = 0; i < 6; i++) begin
      add_edges(64'(8'h10 + i), 64'($urandom), 8, 1'b0);
      if (i < 4) sb.push_back(mk(32'(8'h10 + i), 0, 0, 0, 16'd8, 2'b00));
      run_frame(8, 0, 0, 1'b0, 1'b0, -1);
    end
    check("ovf_set", 64'(ovf), 64'd1);
    check("drop_two", 64'(drop_cnt), 64'd2);
    check("full_valid", 64'(pkt_valid), 64'd1);

    add_edges(64'h5A, 64'($urandom), 8, 1'b1);
    add_edges(64'hFB, 64'($urandom), 8, 1'b1);
    add_edges(64'h12, 64'h34, 8, 1'b1);
    sb.push_back(mk(32'h5A, 32'h3E, 32'h12, 32'h34, 16'd24, 2'b11));
    run_frame(8, 6, 8, 1'b1, 1'b1, -1);
    check("drop_unchanged", 64'(drop_cnt), 64'd2);
    check("sb_after_sync", 64'(sb.size()), 64'd4);
    wait_drain("drain_ovf");

    std_frame();
    run_frame(8, 8, 16, 1'b0, 1'b0, 20);
    pkt_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_valid", 64'(pkt_valid), 64'd0);
    check("post_rst_ovf", 64'(ovf), 64'd0);
    check("post_rst_drop", 64'(drop_cnt), 64'd0);

    std_frame();
    sb.push_back(mk(32'hA5, 32'h3C, 32'h1234, 32'hBEEF, 16'd32, 2'b00));
    run_frame(8, 8, 16, 1'b0, 1'b0, -1);
    wait_drain("drain_after_rst");

    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      bit q;
      int c, a, d, lanes, need, ne;
      q = 1'($urandom);
      c = $urandom_range(0, 36);
      a = $urandom_range(0, 36);
      d = $urandom_range(0, 40);
      if (q && $urandom_range(0, 3) != 0) begin
        c = c & ~3;
        a = a & ~3;
        d = d & ~3;
      end
      lanes = q ? 4 : 1;
      need  = (c + lanes - 1) / lanes + (a + lanes - 1) / lanes + (d + lanes - 1) / lanes;
      ne    = need + int'($urandom_range(0, 6)) - 3;
      if (ne < 0) ne = 0;
      for (int k = 0; k < ne; k++) begin
        e_sdo.push_back(4'($urandom));
        e_sdi.push_back(4'($urandom));
      end
      sb.push_back(model(c, a, d, q));
      run_frame(c, a, d, q, 1'b0, -1);
    end
    wait_drain("drain_random");
    check("final_drop", 64'(drop_cnt), 64'd0);
    check("final_ovf", 64'(ovf), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_frame_collector.md
Name: spi_frame_collector

Overview:
- Synthesisable SPI bus collector, successor to the verification-side collector packet.
- Passively samples SPI master pins, oversampled by the system clock.
- Splits each chip-select frame into cmd, addr and data phases using runtime lengths, in single-lane or quad-lane mode.
- Pushes one tagged packet per frame into a parametrised FIFO. Sits beside the SPI master as an on-chip trace/checker source.

Parameters:
- CMD_W, 32, max cmd bits captured.
- ADDR_W, 32, max addr bits captured.
- DATA_W, 32, max data bits captured per direction (MOSI and MISO).
- FIFO_DEPTH, 4, packet FIFO entries, power of two, ≥2.
- QUAD_EN, 1, 1 allows quad mode. When 0, cfg_quad is ignored (treated as 0).

Ports:
- clk  in  1  system clock, ≥4× SCK frequency.
- rst  in  1  synchronous active-high reset.
- cfg_cmd_len  in  6  cmd phase bits, 0..CMD_W.
- cfg_addr_len  in  6  addr phase bits, 0..ADDR_W.
- cfg_data_len  in  16  data phase bits. Capture saturates at DATA_W.
- cfg_quad  in  1  1 = 4 bits per SCK edge, 0 = 1 bit per edge.
- spi_sck  in  1  SPI clock, CPOL=0, data sampled on rising edge.
- spi_csn  in  1  chip select, active low.
- spi_sdo  in  4  master-out lanes. Bit 0 only in single mode.
- spi_sdi  in  4  master-in lanes. Bit 1 only in single mode.
- pkt_valid  out  1  FIFO head valid.
- pkt_ready  in  1  consumer accepts head.
- pkt_cmd  out  CMD_W  captured cmd, right-aligned.
- pkt_addr  out  ADDR_W  captured addr, right-aligned.
- pkt_mosi  out  DATA_W  captured MOSI data, right-aligned.
- pkt_miso  out  DATA_W  captured MISO data, right-aligned.
- pkt_bits  out  16  total bits (edges × lanes) seen in frame, saturating at 16'hFFFF.
- pkt_flag  out  2  00 exact, 01 short, 10 long, 11 config error.
- ovf  out  1  sticky: a frame was dropped because the FIFO was full. Cleared only by rst.
- drop_cnt  out  8  dropped-frame counter, saturating at 255.

Behaviour:
- Input synchronisation: sck, csn, sdo and sdi each pass through 2-flop synchronisers.
- Edge detection: edges are detected on synchronised sck and csn. Data lanes are sampled from the same sync stage in the cycle the sck rise is detected.
- Reset values: all outputs 0. The csn synchroniser resets to 1. FSM resets to IDLE.
- Reset mid-frame: the frame is discarded and FIFO contents are lost. After reset the FSM stays in IDLE until a csn fall is seen, so a partially observed frame is never captured.
- FSM states: IDLE, CMD, ADDR, DATA, TAIL.
- Frame start: on csn fall, cfg_* is latched (held for the whole frame), field registers and bit counters are cleared, and the FSM moves to the first phase with non-zero length. If all lengths are 0, it goes to TAIL.
- Per sck rise:
  - Shift in 1 bit (sdo[0], sdi[1]) or 4 bits (sdo[3:0], sdi[3:0], lane 3 = MSB).
  - CMD and ADDR capture sdo only. DATA captures sdo into mosi and sdi into miso.
  - The phase counter adds the lane count. The phase ends when count ≥ length; bits of the final nibble beyond the length are discarded. The next non-zero phase follows; after DATA the FSM goes to TAIL.
- DATA beyond DATA_W: the register keeps the last DATA_W bits.
- TAIL: further edges only increment pkt_bits.
- Frame end (csn rise, from any non-IDLE state): flag is resolved as follows.
  - 11 if cfg_cmd_len > CMD_W, cfg_addr_len > ADDR_W, or cfg_quad is set with any non-zero length not a multiple of 4.
  - Otherwise 01 if the FSM is not in TAIL.
  - Otherwise 10 if TAIL saw ≥1 edge.
  - Otherwise 00.
- Push timing: the packet is written at the next clk edge. pkt_valid rises one cycle later if the FIFO was empty.
- FIFO full at push: the packet is dropped, ovf is set, drop_cnt increments. Push and pop in the same cycle when full is a legal pop followed by a push (no drop).
- Handshake: pkt_* hold stable while pkt_valid && !pkt_ready. A pop occurs on pkt_valid && pkt_ready.
- Back-to-back frames: a csn fall in the same cycle as a push is accepted and the new frame starts normally.
- Glitch handling: a csn high pulse shorter than 2 clk may be missed; this is a legal loss and is not flagged.

Decomposition:
- Package spi_collector_pkg: flag enum (FLAG_EXACT, FLAG_SHORT, FLAG_LONG, FLAG_CFG_ERR), phase-state enum, LEN_W=6 and BITS_W=16 localparams.
- Sub-module spi_collector_fifo: parametrised width/depth sync FIFO with show-ahead head, full/empty and a same-cycle push/pop when full.

Test Plan:
- Single mode, cmd=8 (0xA5), addr=8 (0x3C), data=16 (MOSI 0x1234, MISO 0xBEEF), 32 edges -> one packet with those values, pkt_bits=32, flag=00.
- Quad mode, cmd=8, addr=24, data=32, 16 edges, nibbles 0x0B,0x123456,0xCAFEF00D -> fields match, pkt_bits=64, flag=00.
- Single mode, csn rise after 12 of 32 edges -> cmd valid, addr holds its low 4 bits, flag=01. Next frame 36 edges -> flag=10, pkt_bits=36.
- pkt_ready=0, FIFO_DEPTH=4, 6 frames -> 4 stored, ovf=1, drop_cnt=2. Popping returns frames 1-4 in order.
- rst asserted mid-DATA, released while csn low -> no packet until a fresh csn fall. The next full frame is captured with flag=00.
- Quad, cfg_addr_len=6 -> frame completes with flag=11. The FIFO push and the pop of the oldest entry in the same cycle when full -> no drop, drop_cnt unchanged.
